// File: rtl/go_conditioner_if.sv
// Signal bundle between a go_conditioner and its environment: raw request
// and controls in, debounced level, edge pulses and glitch statistics out.
interface go_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             go_raw;
  logic             enable;
  logic             glitch_clr;
  logic             go;
  logic             go_rise;
  logic             go_fall;
  logic             busy;
  logic [CNT_W-1:0] glitch_cnt;

  modport master (
    output go_raw, enable, glitch_clr,
    input  go, go_rise, go_fall, busy, glitch_cnt
  );

  modport slave (
    input  go_raw, enable, glitch_clr,
    output go, go_rise, go_fall, busy, glitch_cnt
  );
endinterface

// File: rtl/go_conditioner.sv
// Synchronises and debounces an asynchronous, bouncing go request into a clean
// level with single-cycle edge pulses and a saturating count of rejected changes.
module go_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic         clk,
  input  logic         rst,
  go_conditioner_if.slave bus
);

  localparam int              CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_ZERO   = CW'(32'd0);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(32'd1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GLITCH_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == GLITCH_MAX) ? v : v + CNT_W'(32'd1);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_go;
  logic                   r_go_rise;
  logic                   r_go_fall;
  logic [CNT_W-1:0]       r_glitch_cnt;
  logic                   w_sync_in;
  logic                   w_reject;

  assign w_sync_in = r_sync[SYNC_STAGES-1];

  // A candidate change is rejected when the input reverts while still enabled.
  assign w_reject = bus.enable &
                    (((r_state == CHK_HI) & ~w_sync_in) |
                     ((r_state == CHK_LO) &  w_sync_in));

  // Metastability synchroniser chain for the raw request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.go_raw};
    end
  end

  // Debounce FSM with registered level and edge-pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOW;
      r_cnt     <= CNT_ZERO;
      r_go      <= 1'b0;
      r_go_rise <= 1'b0;
      r_go_fall <= 1'b0;
    end else begin
      r_go_rise <= 1'b0;
      r_go_fall <= 1'b0;
      case (r_state)
        LOW: begin
          if (bus.enable && w_sync_in) begin
            r_state <= CHK_HI;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= LOW;
            r_cnt   <= CNT_ZERO;
          end
        end
        CHK_HI: begin
          if (!bus.enable || !w_sync_in) begin
            r_state <= LOW;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= HIGH;
            r_cnt     <= CNT_ZERO;
            r_go      <= 1'b1;
            r_go_rise <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (bus.enable && !w_sync_in) begin
            r_state <= CHK_LO;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= HIGH;
            r_cnt   <= CNT_ZERO;
          end
        end
        CHK_LO: begin
          if (!bus.enable || w_sync_in) begin
            r_state <= HIGH;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= LOW;
            r_cnt     <= CNT_ZERO;
            r_go      <= 1'b0;
            r_go_fall <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= LOW;
          r_cnt   <= CNT_ZERO;
          r_go    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating rejection counter; an explicit clear wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_glitch_cnt <= '0;
    end else if (bus.glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_reject) begin
      r_glitch_cnt <= sat_inc(r_glitch_cnt);
    end else begin
      r_glitch_cnt <= r_glitch_cnt;
    end
  end

  assign bus.go         = r_go;
  assign bus.go_rise    = r_go_rise;
  assign bus.go_fall    = r_go_fall;
  assign bus.busy       = (r_state == CHK_HI) || (r_state == CHK_LO);
  assign bus.glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_go_conditioner.sv
// Directed bench for go_conditioner: a run-length debounce model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_go_conditioner;

  localparam int S   = 2;
  localparam int D   = 4;
  localparam int W   = 2;
  localparam int GMX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  go_conditioner_if #(.CNT_W(W)) bus_if ();

  go_conditioner #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Model: go flips after D consecutive enabled cycles where the synchronised
  // input disagrees with go; an enabled revert before that is a glitch.
  typedef struct {
    logic [S-1:0] sh;
    logic         go;
    int           run;
    int           glitch;
    logic         rise;
    logic         fall;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t c, input logic raw,
                                  input logic en, input logic clr);
    model_t n = c;
    logic   sync_v = c.sh[S-1];
    logic   rej = 1'b0;
    n.sh   = {c.sh[S-2:0], raw};
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (!en) begin
      n.run = 0;
    end else if (sync_v != c.go) begin
      n.run = c.run + 1;
      if (n.run == D) begin
        n.go   = sync_v;
        n.rise = sync_v;
        n.fall = !sync_v;
        n.run  = 0;
      end
    end else begin
      rej   = (c.run > 0);
      n.run = 0;
    end
    if (clr) n.glitch = 0;
    else if (rej && c.glitch < GMX) n.glitch = c.glitch + 1;
    return n;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.sh = '0; r.go = 1'b0; r.run = 0; r.glitch = 0; r.rise = 1'b0; r.fall = 1'b0;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= step(m, bus_if.go_raw, bus_if.enable, bus_if.glitch_clr);
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("model_go",      int'(bus_if.go),         int'(m.go));
    cmp("model_go_rise", int'(bus_if.go_rise),    int'(m.rise));
    cmp("model_go_fall", int'(bus_if.go_fall),    int'(m.fall));
    cmp("model_busy",    int'(bus_if.busy),       int'(m.run > 0));
    cmp("model_glitch",  int'(bus_if.glitch_cnt), m.glitch);
    cmp("pulse_excl",    int'(bus_if.go_rise & bus_if.go_fall), 0);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bounce();
    bus_if.go_raw = 1'b1;
    cycles(2);
    bus_if.go_raw = 1'b0;
    cycles(4);
  endtask

  int busy_n;
  int pulse_n;

  initial begin
    rst = 1'b1;
    bus_if.go_raw     = 1'b0;
    bus_if.enable     = 1'b1;
    bus_if.glitch_clr = 1'b0;
    #1;
    cmp("rst_go",     int'(bus_if.go), 0);
    cmp("rst_busy",   int'(bus_if.busy), 0);
    cmp("rst_glitch", int'(bus_if.glitch_cnt), 0);
    cycles(3);
    rst = 1'b0;
    cycles(3);

    // Clean rise: go on edge 6, busy for 3 cycles, one rise pulse.
    bus_if.go_raw = 1'b1;
    busy_n = 0;
    for (int i = 1; i <= 6; i++) begin
      cycles(1);
      busy_n += int'(bus_if.busy);
      if (i == 5) cmp("rise_go_e5", int'(bus_if.go), 0);
    end
    cmp("rise_go_e6",   int'(bus_if.go), 1);
    cmp("rise_pulse",   int'(bus_if.go_rise), 1);
    cmp("rise_busy_n",  busy_n, 3);
    cycles(1);
    cmp("rise_pulse_1", int'(bus_if.go_rise), 0);
    cmp("rise_glitch",  int'(bus_if.glitch_cnt), 0);

    // Clean fall from HIGH.
    bus_if.go_raw = 1'b0;
    pulse_n = 0;
    for (int i = 1; i <= 6; i++) begin
      cycles(1);
      pulse_n += int'(bus_if.go_fall);
      if (i == 5) cmp("fall_go_e5", int'(bus_if.go), 1);
    end
    cmp("fall_go_e6", int'(bus_if.go), 0);
    cmp("fall_pulse", int'(bus_if.go_fall), 1);
    cycles(2);
    cmp("fall_pulse_n", pulse_n, 1);

    // Bounce: two-cycle high is rejected.
    pulse_n = 0;
    bus_if.go_raw = 1'b1;
    cycles(1); pulse_n += int'(bus_if.go_rise);
    cycles(1); pulse_n += int'(bus_if.go_rise);
    bus_if.go_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      pulse_n += int'(bus_if.go_rise) + int'(bus_if.go_fall);
    end
    cmp("bounce_go",     int'(bus_if.go), 0);
    cmp("bounce_pulses", pulse_n, 0);
    cmp("bounce_glitch", int'(bus_if.glitch_cnt), 1);

    // Abort from CHK_HI, then full re-qualification once enabled again.
    bus_if.go_raw = 1'b1;
    cycles(4);
    cmp("abort_busy_pre", int'(bus_if.busy), 1);
    bus_if.enable = 1'b0;
    cycles(1);
    cmp("abort_busy",   int'(bus_if.busy), 0);
    cmp("abort_go",     int'(bus_if.go), 0);
    cmp("abort_glitch", int'(bus_if.glitch_cnt), 1);
    cycles(3);
    cmp("frozen_busy",  int'(bus_if.busy), 0);
    bus_if.enable = 1'b1;
    cycles(3);
    cmp("reen_go_e3", int'(bus_if.go), 0);
    cycles(1);
    cmp("reen_go_e4", int'(bus_if.go), 1);
    bus_if.go_raw = 1'b0;
    cycles(8);
    cmp("reen_fall_go", int'(bus_if.go), 0);

    // Saturation and clear priority.
    bus_if.glitch_clr = 1'b1;
    cycles(1);
    bus_if.glitch_clr = 1'b0;
    cmp("clr_glitch", int'(bus_if.glitch_cnt), 0);
    for (int i = 0; i < 3; i++) bounce();
    cmp("sat_glitch_3", int'(bus_if.glitch_cnt), 3);
    for (int i = 0; i < 2; i++) bounce();
    cmp("sat_glitch_5", int'(bus_if.glitch_cnt), 3);
    bus_if.go_raw = 1'b1;
    cycles(2);
    bus_if.go_raw = 1'b0;
    cycles(2);
    cmp("sixth_busy", int'(bus_if.busy), 1);
    bus_if.glitch_clr = 1'b1;
    cycles(1);
    bus_if.glitch_clr = 1'b0;
    cmp("clr_prio_busy",   int'(bus_if.busy), 0);
    cmp("clr_prio_glitch", int'(bus_if.glitch_cnt), 0);
    cycles(3);

    // Reset mid-CHK_HI, then full latency after release.
    bounce();
    cmp("pre_rst_glitch", int'(bus_if.glitch_cnt), 1);
    bus_if.go_raw = 1'b1;
    cycles(4);
    cmp("pre_rst_busy", int'(bus_if.busy), 1);
    rst = 1'b1;
    #1;
    cmp("mid_rst_busy",   int'(bus_if.busy), 0);
    cmp("mid_rst_go",     int'(bus_if.go), 0);
    cmp("mid_rst_rise",   int'(bus_if.go_rise), 0);
    cmp("mid_rst_fall",   int'(bus_if.go_fall), 0);
    cmp("mid_rst_glitch", int'(bus_if.glitch_cnt), 0);
    cycles(1);
    rst = 1'b0;
    cycles(5);
    cmp("post_rst_go_e5", int'(bus_if.go), 0);
    cycles(1);
    cmp("post_rst_go_e6", int'(bus_if.go), 1);
    cmp("post_rst_rise",  int'(bus_if.go_rise), 1);
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
